// File: rtl/dynrama_blk_alloc.sv
// dynrama_blk_alloc: bitmap block allocator serving alloc/free requests from round-robin arbitrated channels.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mode                  0 = first-fit from block 0, 1 = LFSR random start block
//   req_valid/req_ready   per-channel request handshake (req_ready is a one-cycle one-hot grant)
//   req_op                per channel: 0 = alloc, 1 = free
//   req_size              per channel byte size, AWIDTH+1 bits each
//   req_addr              per channel free address, AWIDTH bits each
//   rsp_valid/rsp_ready   response handshake; rsp_ch/rsp_ok/rsp_addr held until accepted
//   free_blks             number of free blocks in the bitmap
module dynrama_blk_alloc #(
  parameter int              AWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = '0,
  parameter int              BLK_SHIFT = 12,
  parameter int              NUM_BLKS  = 64,
  parameter int              NUM_CH    = 2,
  parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      mode,
  input  logic [NUM_CH-1:0]                         req_valid,
  output logic [NUM_CH-1:0]                         req_ready,
  input  logic [NUM_CH-1:0]                         req_op,
  input  logic [NUM_CH*(AWIDTH+1)-1:0]              req_size,
  input  logic [NUM_CH*AWIDTH-1:0]                  req_addr,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] rsp_ch,
  output logic                                      rsp_ok,
  output logic [AWIDTH-1:0]                         rsp_addr,
  output logic [$clog2(NUM_BLKS+1)-1:0]             free_blks
);
  localparam int SW  = AWIDTH + 1;
  localparam int LW  = $clog2(NUM_BLKS);
  localparam int FW  = $clog2(NUM_BLKS + 1);
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] SCAN   = 3'd2;
  localparam logic [2:0] MARK   = 3'd3;
  localparam logic [2:0] VERIFY = 3'd4;
  localparam logic [2:0] CLEAR  = 3'd5;
  localparam logic [2:0] RESP   = 3'd6;
  localparam logic [SW:0]   RND   = {{(SW+1-BLK_SHIFT){1'b0}}, {BLK_SHIFT{1'b1}}};
  localparam logic [SW-1:0] NB_M1 = SW'(NUM_BLKS - 1);

  logic [2:0]          state_q, state_d;
  logic [NUM_BLKS-1:0] map_q, map_d;
  logic [FW-1:0]       freeb_q, freeb_d;
  logic [CHW-1:0]      rr_q, rr_d, ch_q, ch_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [SW-1:0]       nblk_q, nblk_d;
  logic [AWIDTH-1:0]   addr_q, addr_d, raddr_q, raddr_d;
  logic [LW-1:0]       p_q, p_d, rs_q, rs_d;
  logic [LW:0]         run_q, run_d, cnt_q, cnt_d;
  logic [LW+1:0]       exam_q, exam_d;
  logic                ok_q, ok_d;

  logic           found, hi;
  logic [CHW-1:0] gnt, gnt_hi, gnt_lo;
  logic           sel_op;
  logic [SW-1:0]  sel_size;
  logic [AWIDTH-1:0] sel_addr;

  // Round-robin: lowest valid channel at or above rr_q, else lowest valid overall.
  always_comb begin
    hi = 1'b0;
    gnt_hi = '0;
    gnt_lo = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (req_valid[c]) begin
        if (CHW'(c) >= rr_q) begin
          gnt_hi = CHW'(c);
          hi = 1'b1;
        end
        gnt_lo = CHW'(c);
      end
    end
    found = |req_valid;
    gnt = hi ? gnt_hi : gnt_lo;
    sel_op = 1'b0;
    sel_size = '0;
    sel_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CHW'(c) == gnt) begin
        sel_op = req_op[c];
        sel_size = req_size[c*SW +: SW];
        sel_addr = req_addr[c*AWIDTH +: AWIDTH];
      end
    end
  end

  logic [SW:0]   sz_rnd;
  logic [SW-1:0] nblk_w, off, idx;
  logic          verr, last, bfree;
  logic [LW-1:0] vi, mi;
  logic [LW:0]   run_n;
  logic [LW-1:0] rs_n;
  logic [LW+1:0] exam_n;

  always_comb begin
    sz_rnd = {1'b0, sel_size} + RND;
    nblk_w = SW'(sz_rnd >> BLK_SHIFT);
    off = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    idx = off >> BLK_SHIFT;
    // Free is rejected for empty size, address below the region, misalignment or running past the last block.
    verr = nblk_q == '0 || addr_q < BASE_ADDR || |off[BLK_SHIFT-1:0] || idx + nblk_q > SW'(NUM_BLKS);
    vi = LW'(idx) + LW'(cnt_q);
    mi = rs_q + LW'(cnt_q);
    last = SW'(cnt_q) == nblk_q - 1'b1;
    bfree = !map_q[p_q];
    run_n = bfree ? run_q + 1'b1 : '0;
    rs_n = bfree && run_q == '0 ? p_q : rs_q;
    exam_n = exam_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    map_d = map_q;
    freeb_d = freeb_q;
    rr_d = rr_q;
    ch_d = ch_q;
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    nblk_d = nblk_q;
    addr_d = addr_q;
    raddr_d = raddr_q;
    p_d = p_q;
    rs_d = rs_q;
    run_d = run_q;
    cnt_d = cnt_q;
    exam_d = exam_q;
    ok_d = ok_q;
    case (state_q)
      IDLE: if (found) begin
        ch_d = gnt;
        rr_d = gnt == CHW'(NUM_CH - 1) ? '0 : gnt + 1'b1;
        nblk_d = nblk_w;
        addr_d = sel_addr;
        p_d = mode ? lfsr_q[LW-1:0] : '0;
        run_d = '0;
        exam_d = '0;
        cnt_d = '0;
        ok_d = 1'b0;
        raddr_d = '0;
        state_d = sel_op ? VERIFY : CHECK;
      end
      CHECK: state_d = nblk_q == '0 || nblk_q > SW'(freeb_q) ? RESP : SCAN;
      SCAN: begin
        if (SW'(run_n) == nblk_q) begin
          rs_d = rs_n;
          cnt_d = '0;
          state_d = MARK;
        end else if (SW'(exam_n) >= nblk_q + NB_M1) begin
          state_d = RESP;
        end else begin
          // Leaving the last block drops the run so a run never spans the wrap.
          run_d = p_q == LW'(NUM_BLKS - 1) ? '0 : run_n;
          rs_d = rs_n;
          p_d = p_q + 1'b1;
          exam_d = exam_n;
        end
      end
      MARK: begin
        map_d[mi] = 1'b1;
        freeb_d = freeb_q - 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          ok_d = 1'b1;
          raddr_d = BASE_ADDR + (AWIDTH'(rs_q) << BLK_SHIFT);
          state_d = RESP;
        end
      end
      VERIFY: begin
        if (verr || !map_q[vi]) state_d = RESP;
        else if (last) begin
          cnt_d = '0;
          state_d = CLEAR;
        end else cnt_d = cnt_q + 1'b1;
      end
      CLEAR: begin
        map_d[vi] = 1'b0;
        freeb_d = freeb_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          ok_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      map_q <= '0;
      freeb_q <= FW'(NUM_BLKS);
      rr_q <= '0;
      ch_q <= '0;
      lfsr_q <= LFSR_SEED;
      nblk_q <= '0;
      addr_q <= '0;
      raddr_q <= '0;
      p_q <= '0;
      rs_q <= '0;
      run_q <= '0;
      cnt_q <= '0;
      exam_q <= '0;
      ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q <= map_d;
      freeb_q <= freeb_d;
      rr_q <= rr_d;
      ch_q <= ch_d;
      lfsr_q <= lfsr_d;
      nblk_q <= nblk_d;
      addr_q <= addr_d;
      raddr_q <= raddr_d;
      p_q <= p_d;
      rs_q <= rs_d;
      run_q <= run_d;
      cnt_q <= cnt_d;
      exam_q <= exam_d;
      ok_q <= ok_d;
    end
  end

  assign req_ready = state_q == IDLE && found && rst_n ? NUM_CH'(1) << gnt : '0;
  assign rsp_valid = state_q == RESP;
  assign rsp_ch = ch_q;
  assign rsp_ok = ok_q;
  assign rsp_addr = raddr_q;
  assign free_blks = freeb_q;
endmodule

// File: doc/dynrama_blk_alloc.md
Name: dynrama_blk_alloc

Overview:
- Synthesizable hardware successor to the dynrama allocator.
- Manages a contiguous region of NUM_BLKS fixed-size blocks with an occupancy bitmap.
- Serves alloc/free requests from NUM_CH requester channels through round-robin arbitration.
- Supports first-fit or LFSR-randomised start placement; used by traffic generators and DMA models that need non-overlapping buffers at runtime.

Parameters:
- AWIDTH, 32: address width (bits); size fields are AWIDTH+1 bits.
- BASE_ADDR, 0: byte address of block 0; must be block-aligned.
- BLK_SHIFT, 12: log2 of block size in bytes (4 KB).
- NUM_BLKS, 64: blocks managed; power of 2, range 2..1024.
- NUM_CH, 2: requester channels, range 1..8.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- mode  in  1  0 = first-fit from block 0; 1 = random start index.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  one-hot accept pulse.
- req_op  in  NUM_CH  per channel: 0 = alloc, 1 = free.
- req_size  in  NUM_CH*(AWIDTH+1)  byte size per channel.
- req_addr  in  NUM_CH*AWIDTH  free address per channel; ignored for alloc.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_ch  out  CHW=max(1,$clog2(NUM_CH))  channel served.
- rsp_ok  out  1  1 = success.
- rsp_addr  out  AWIDTH  allocated base address; 0 on failure or free.
- free_blks  out  $clog2(NUM_BLKS+1)  current free-block count.

Behaviour:
- Reset, on any rst_n=0 clock edge, including mid-operation:
  - Any in-flight operation is aborted.
  - Bitmap cleared to all free; free_blks=NUM_BLKS.
  - FSM to IDLE; rr pointer=0; lfsr=LFSR_SEED.
  - Outputs: req_ready=0, rsp_valid=0, rsp_ok=0, rsp_addr=0, rsp_ch=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clock regardless of state.
- FSM states: IDLE, CHECK, SCAN, MARK, VERIFY, CLEAR, RESP.
- IDLE:
  - If any req_valid, grant the first set channel at or after the rr pointer.
  - Drive req_ready[g]=1 for that cycle only; latch op, size, addr and g; set rr pointer = g+1 mod NUM_CH.
  - Compute nblk=ceil(size/2^BLK_SHIFT) and start = mode ? lfsr[log2 NUM_BLKS-1:0] : 0.
  - Next state is CHECK for alloc, VERIFY for free.
- CHECK (1 cycle):
  - If nblk==0 or nblk>free_blks, go to RESP with fail.
  - Otherwise init p=start, run=0, examined=0, and go to SCAN.
- SCAN, one bitmap bit per cycle:
  - If bit[p] is free: run++, and rs=p when run was 0. Else run=0.
  - p wraps from NUM_BLKS-1 to 0; the wrap forces run=0, so runs never span the wrap.
  - If run reaches nblk, go to MARK.
  - Else if examined reaches NUM_BLKS+nblk-1, go to RESP with fail.
- MARK: set bit[rs..rs+nblk-1] one per cycle; free_blks decrements per bit. Then RESP with ok and rsp_addr = BASE_ADDR + (rs<<BLK_SHIFT).
- VERIFY:
  - Immediate fail if any of these hold:
    - size==0.
    - addr<BASE_ADDR.
    - addr is misaligned.
    - idx=(addr-BASE_ADDR)>>BLK_SHIFT plus nblk exceeds NUM_BLKS.
  - Otherwise check bit[idx..idx+nblk-1] one per cycle. Any free bit means fail with the bitmap untouched; all set goes to CLEAR.
- CLEAR: clear bits one per cycle; free_blks increments per bit. Then RESP with ok and rsp_addr=0.
- RESP:
  - rsp_valid=1 with rsp_ch, rsp_ok and rsp_addr stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE; rsp_valid drops the next cycle.
  - No new request is accepted before then (one operation outstanding).
- Latency, from the accept cycle T to the first rsp_valid cycle:
  - Alloc success: 2 + (SCAN cycles) + nblk.
  - Example: empty map, first-fit, nblk=1 gives rsp_valid at T+4.
  - Size or capacity fail: T+2.
- Arithmetic: all address math is done at AWIDTH+1 bits; an end address above 2^AWIDTH is out of range, i.e. fail.
- Invariant: free_blks always equals the number of zero bits in the bitmap.

Test Plan:
- Reset, then mode=0, ch0 alloc 4096 → rsp_valid at T+4, rsp_ok=1, rsp_addr=BASE_ADDR, free_blks=63; then alloc 5000 → rsp_addr=BASE_ADDR+0x1000, free_blks=61.
- Fragmentation: alloc 1, 1, 1 blocks (blocks 0..2); free BASE+0x1000 size 4096; alloc 8192 → rsp_addr=BASE+0x3000 (hole too small); alloc 4096 → BASE+0x1000.
- Free errors: free BASE+0x800 (misaligned), double-free of block 5, and size 0 → each gives rsp_ok=0 with free_blks unchanged; alloc 64 blocks on a map holding 1 block → fail at T+2.
- Arbitration: ch0 and ch1 both valid with alloc 4096 each → ch0 granted first (rsp_ch=0), ch1 next; hold rsp_ready=0 for 5 cycles → rsp fields stable and req_ready stays 0 throughout.
- mode=1: 64 single-block allocs → all ok, all addresses aligned and distinct within the region, free_blks=0; 65th alloc → rsp_ok=0.
- Assert rst_n=0 during MARK of a 4-block alloc → next cycle free_blks=64 and rsp_valid=0; subsequent first-fit alloc 4096 → BASE_ADDR.
